spike_event_queue: RTL and testbench

Producer-side counterpart of the network controller's spike-input handshake. Buffers presynaptic spike indices from the spike source in a small FIFO and offers them one at a time on `input_occurred`/`input_index`, holding each until the controller answers with `input_ack`. It sits between the spike source (external stimulus or neuron fire logic) and the network controller. It also raises a sticky flag if the controller stalls.

---
 rtl/spike_event_queue.sv | 162 ++++++++++++++++
 tb/tb_spike_event_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_queue.sv
// spike_event_queue
//
// Buffers presynaptic spike indices from a spike source in a small FIFO and
// offers them one at a time to the network controller. Each entry is held on
// input_occurred/input_index until the controller answers with input_ack.
// A sticky ack_timeout flag is raised if one entry is offered for ACK_TIMEOUT
// cycles without an ack. The offered entry itself is never discarded.
//
// Optional statistics are enabled with the macro SPIKE_QUEUE_STATS_EN:
//   drop_count - spikes lost to a full queue (saturating at 16'hFFFF)
//   peak_level - high-water mark of level since reset (flush keeps it)
// Without the macro both outputs are tied to zero.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   synchronous active-low reset
//   spike_valid    in   source presents a spike this cycle
//   spike_index    in   presynaptic index of that spike (IW bits)
//   spike_ready    out  queue can accept (level != FIFO_DEPTH)
//   flush          in   discard all queued and offered entries
//   input_occurred out  an entry is offered to the controller
//   input_index    out  index of the offered entry (FIFO head)
//   input_ack      in   controller has registered the offered entry
//   level          out  current occupancy
//   ack_timeout    out  sticky stall flag (cleared only by reset)
//   drop_count     out  dropped spike count (stats build only)
//   peak_level     out  maximum occupancy since reset (stats build only)

module spike_event_queue #(
    parameter int SR_DEPTH    = 16384,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 64,
    localparam int IW = $clog2(SR_DEPTH),
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spike_valid,
    input  logic [IW-1:0] spike_index,
    output logic          spike_ready,
    input  logic          flush,
    output logic          input_occurred,
    output logic [IW-1:0] input_index,
    input  logic          input_ack,
    output logic [LW-1:0] level,
    output logic          ack_timeout,
    output logic [15:0]   drop_count,
    output logic [LW-1:0] peak_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STALL_MAX  = SW'(ACK_TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [SW-1:0] stall_cnt;

    logic          push;
    logic          pop;
    logic [LW-1:0] level_after_pop;
    logic [LW-1:0] level_next;
    logic [PW-1:0] rd_ptr_next;
    logic [IW-1:0] head_next;
    logic [SW-1:0] stall_inc;

    // No full-bypass: readiness depends only on the registered level.
    assign spike_ready    = (level != FULL_LEVEL);
    assign input_occurred = (state == OFFER);

    always_comb begin
        push            = spike_valid && spike_ready;
        pop             = input_ack && (state == OFFER);
        level_after_pop = level - LW'(pop);
        level_next      = level_after_pop + LW'(push);
        rd_ptr_next     = rd_ptr + PW'(pop);
        // If nothing stored survives the pop, the new head is the spike
        // being written this cycle (it is not in mem yet).
        if (level_after_pop == '0) begin
            head_next = spike_index;
        end else begin
            head_next = mem[rd_ptr_next];
        end
        stall_inc = (stall_cnt == STALL_MAX) ? STALL_MAX : stall_cnt + SW'(1);
    end

    // Storage array carries no reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && push) begin
            mem[wr_ptr] <= spike_index;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            input_index <= '0;
            stall_cnt   <= '0;
            ack_timeout <= 1'b0;
        end else if (flush) begin
            // Flush wins over push and pop; the stall flag is deliberately kept.
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            if (level_next != '0) begin
                state       <= OFFER;
                input_index <= head_next;
            end else begin
                state <= IDLE;
            end
            // Count cycles the current head has been offered without an ack.
            if ((state == OFFER) && !pop) begin
                stall_cnt <= stall_inc;
                if (stall_inc == STALL_MAX) begin
                    ack_timeout <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

`ifdef SPIKE_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_count <= '0;
            peak_level <= '0;
        end else if (!flush) begin
            if (spike_valid && !spike_ready && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            // Track against the next level so the mark is current with level.
            if (level_next > peak_level) begin
                peak_level <= level_next;
            end
        end
    end
`else
    assign drop_count = '0;
    assign peak_level = '0;
`endif

endmodule

// File: tb/tb_spike_event_queue.sv
// Self-checking bench for spike_event_queue: directed steps followed by a
// randomized phase, all compared cycle by cycle against a queue-based model.

module tb_spike_event_queue;

    localparam int SR_DEPTH    = 16384;
    localparam int FIFO_DEPTH  = 8;
    localparam int ACK_TIMEOUT = 64;
    localparam int IW = $clog2(SR_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spike_valid = 1'b0;
    logic [IW-1:0] spike_index = '0;
    logic          spike_ready;
    logic          flush = 1'b0;
    logic          input_occurred;
    logic [IW-1:0] input_index;
    logic          input_ack = 1'b0;
    logic [LW-1:0] level;
    logic          ack_timeout;
    logic [15:0]   drop_count;
    logic [LW-1:0] peak_level;

    spike_event_queue #(
        .SR_DEPTH   (SR_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spike_valid   (spike_valid),
        .spike_index   (spike_index),
        .spike_ready   (spike_ready),
        .flush         (flush),
        .input_occurred(input_occurred),
        .input_index   (input_index),
        .input_ack     (input_ack),
        .level         (level),
        .ack_timeout   (ack_timeout),
        .drop_count    (drop_count),
        .peak_level    (peak_level)
    );

    always #5 clk = ~clk;

    // Reference model: queue contents plus stall/flag/statistics bookkeeping.
    int q[$];
    int unacked_cycles = 0;
    bit model_timeout = 1'b0;
    int model_drops = 0;
    int model_peak = 0;

    int errors = 0;
    int checks = 0;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic v, input int idx, input logic a, input logic f);
        bit occupied, ready, do_pop, do_push;
        if (f) begin
            q.delete();
            unacked_cycles = 0;
            return;
        end
        occupied = (q.size() > 0);
        ready    = (q.size() != FIFO_DEPTH);
        do_pop   = a && occupied;
        do_push  = v && ready;
        if (occupied && !do_pop) begin
            if (unacked_cycles < ACK_TIMEOUT) unacked_cycles++;
            if (unacked_cycles == ACK_TIMEOUT) model_timeout = 1'b1;
        end else begin
            unacked_cycles = 0;
        end
        if (v && !ready && model_drops < 65535) model_drops++;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(idx);
        if (q.size() > model_peak) model_peak = q.size();
    endtask

    task automatic checkOutput();
        checkValue("level", 32'(level), 32'(q.size()));
        checkValue("spike_ready", 32'(spike_ready), 32'(q.size() != FIFO_DEPTH));
        checkValue("input_occurred", 32'(input_occurred), 32'(q.size() > 0));
        if (q.size() > 0) checkValue("input_index", 32'(input_index), 32'(q[0]));
        checkValue("ack_timeout", 32'(ack_timeout), 32'(model_timeout));
`ifdef SPIKE_QUEUE_STATS_EN
        checkValue("drop_count", 32'(drop_count), 32'(model_drops));
        checkValue("peak_level", 32'(peak_level), 32'(model_peak));
`else
        checkValue("drop_count", 32'(drop_count), 32'd0);
        checkValue("peak_level", 32'(peak_level), 32'd0);
`endif
    endtask

    task automatic applyStimulus(input logic v, input int idx, input logic a, input logic f);
        spike_valid = v;
        spike_index = IW'(idx);
        input_ack   = a;
        flush       = f;
        @(posedge clk);
        modelEdge(v, idx, a, f);
        #1;
        checkOutput();
    endtask

    task automatic applyReset();
        reset_n     = 1'b0;
        spike_valid = 1'b0;
        input_ack   = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        q.delete();
        unacked_cycles = 0;
        model_timeout  = 1'b0;
        model_drops    = 0;
        model_peak     = 0;
        #1;
        checkOutput();
        checkValue("rst_input_index", 32'(input_index), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        int ack_rate;
        int push_rate;
        $display("[TB] spike_event_queue bench start");

        // Reset, single push then delayed ack.
        applyReset();
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        checkValue("t1_occurred", 32'(input_occurred), 32'd1);
        checkValue("t1_index", 32'(input_index), 32'd5);
        checkValue("t1_level", 32'(level), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkValue("t1_idle", 32'(input_occurred), 32'd0);
        checkValue("t1_level0", 32'(level), 32'd0);

        // Ack while idle is ignored.
        applyStimulus(1'b0, 0, 1'b1, 1'b0);

        // Fill to full, overflow, then drain in order.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        checkValue("full_level", 32'(level), 32'd8);
        checkValue("full_ready", 32'(spike_ready), 32'd0);
        applyStimulus(1'b1, 9, 1'b0, 1'b0);
`ifdef SPIKE_QUEUE_STATS_EN
        checkValue("full_drop", 32'(drop_count), 32'd1);
        checkValue("full_peak", 32'(peak_level), 32'd8);
`endif
        for (int i = 1; i <= 8; i++) begin
            checkValue("drain_head", 32'(input_index), 32'(i));
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            if (i == 1) checkValue("drain_ready", 32'(spike_ready), 32'd1);
        end
        checkValue("drain_empty", 32'(input_occurred), 32'd0);

        // Simultaneous push and pop at level 3.
        for (int i = 10; i <= 12; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        applyStimulus(1'b1, 13, 1'b1, 1'b0);
        checkValue("pp_level", 32'(level), 32'd3);
        checkValue("pp_head", 32'(input_index), 32'd11);
        repeat (3) applyStimulus(1'b0, 0, 1'b1, 1'b0);

        // Full with same-cycle pop still refuses the push.
        for (int i = 20; i < 28; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        applyStimulus(1'b1, 99, 1'b1, 1'b0);
        checkValue("nobypass_level", 32'(level), 32'd7);
        repeat (7) applyStimulus(1'b0, 0, 1'b1, 1'b0);

        // Ack timeout.
        applyReset();
        applyStimulus(1'b1, 7, 1'b0, 1'b0);
        repeat (63) applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkValue("to_before", 32'(ack_timeout), 32'd0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkValue("to_set", 32'(ack_timeout), 32'd1);
        checkValue("to_kept_entry", 32'(input_index), 32'd7);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkValue("to_pop_level", 32'(level), 32'd0);
        checkValue("to_sticky", 32'(ack_timeout), 32'd1);

        // Flush with simultaneous push and ack.
        for (int i = 30; i < 34; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        applyStimulus(1'b1, 77, 1'b1, 1'b1);
        checkValue("fl_level", 32'(level), 32'd0);
        checkValue("fl_occurred", 32'(input_occurred), 32'd0);
        checkValue("fl_timeout_kept", 32'(ack_timeout), 32'd1);

        // Reset mid-operation, then a maximum index.
        for (int i = 40; i < 45; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        checkValue("mid_level", 32'(level), 32'd5);
        applyReset();
        applyStimulus(1'b1, 16383, 1'b0, 1'b0);
        checkValue("max_index", 32'(input_index), 32'd16383);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);

        // Randomized phases with different producer/consumer balance.
        for (int phase = 0; phase < 4; phase++) begin
            applyReset();
            case (phase)
                0: begin ack_rate = 90; push_rate = 50; end
                1: begin ack_rate = 50; push_rate = 60; end
                2: begin ack_rate = 15; push_rate = 70; end
                default: begin ack_rate = 3; push_rate = 20; end
            endcase
            for (int i = 0; i < 700; i++) begin
                applyStimulus($urandom_range(0, 99) < push_rate,
                              int'($urandom_range(0, SR_DEPTH - 1)),
                              $urandom_range(0, 99) < ack_rate,
                              $urandom_range(0, 199) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
